// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and fetch sequencer feeding instruction decode
// Tracks boot delay, stall, halt/resume, misaligned-redirect fault and retired count.
module pc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             PCsrc,
  input  logic [31:0]      ImmOp,
  output logic [31:0]      PC,
  output logic             pc_valid,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = (BOOT_CYCLES > 0) ? BW'(BOOT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [BW-1:0]     boot_cnt_q, boot_cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       tgt;
  logic              adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      boot_cnt_q   <= '0;
      pc_q         <= RESET_PC;
      fault_addr_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    cnt_d        = cnt_q;
    adv          = 1'b0;
    tgt          = pc_q + ImmOp;

    case (state_q)
      S_BOOT: begin
        if (BOOT_CYCLES == 0 || boot_cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BW'(1);
        end
      end
      S_RUN: begin
        // Stall drops PCsrc on the floor: decode holds the branch and re-presents it.
        if (halt_req) begin
          state_d = S_HALT;
        end else if (stall) begin
          state_d = S_RUN;
        end else if (PCsrc) begin
          if (tgt[1:0] != 2'b00) begin
            state_d      = S_FAULT;
            fault_addr_d = tgt;
          end else begin
            pc_d = tgt;
            adv  = 1'b1;
          end
        end else begin
          pc_d = pc_q + 32'd4;
          adv  = 1'b1;
        end
      end
      S_HALT: begin
        if (resume && !halt_req) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (adv && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign PC          = pc_q;
  assign pc_valid    = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign fault_addr  = fault_addr_q;
  assign instr_count = cnt_q;

endmodule
